// File: rtl/vx_csr_access_pkg.sv
// Shared types and constants for the CSR access front-end:
// operation encoding, queued response bundle and the FP-CSR address list.
package vx_csr_access_pkg;

    localparam int UUID_BITS     = 8;
    localparam int NUM_THREADS   = 4;
    localparam int NUM_WARPS     = 4;
    localparam int NW_BITS       = 2;
    localparam int NR_BITS       = 5;
    localparam int CSR_ADDR_BITS = 12;
    localparam int PERF_CTR_BITS = 16;

    typedef enum logic [1:0] {
        CSR_RW = 2'd0,
        CSR_RS = 2'd1,
        CSR_RC = 2'd2
    } csr_op_t;

    localparam logic [CSR_ADDR_BITS-1:0] CSR_FFLAGS = 12'h001;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_FRM    = 12'h002;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_FCSR   = 12'h003;

    typedef struct packed {
        logic [UUID_BITS-1:0]   uuid;
        logic [NW_BITS-1:0]     wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [31:0]            pc;
        logic [NR_BITS-1:0]     rd;
        logic                   wb;
        logic [31:0]            data;
    } csr_rsp_t;

    function automatic logic is_fp_csr(input logic [CSR_ADDR_BITS-1:0] a);
        return (a == CSR_FFLAGS) || (a == CSR_FRM) || (a == CSR_FCSR);
    endfunction

endpackage

// File: rtl/vx_csr_access_rsp_queue.sv
// Response FIFO of csr_rsp_t with valid/ready on both sides.
// Ports: i_push_*/o_push_ready in, o_pop_*/i_pop_ready out, o_full/o_empty.
module vx_csr_access_rsp_queue
    import vx_csr_access_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_push_valid,
    output logic     o_push_ready,
    input  csr_rsp_t i_push_data,
    output logic     o_pop_valid,
    input  logic     i_pop_ready,
    output csr_rsp_t o_pop_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    csr_rsp_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    // Full blocks pushes even when a pop happens in the same cycle.
    assign o_full       = (r_count == FULL_CNT);
    assign o_empty      = (r_count == '0);
    assign o_push_ready = !o_full;
    assign o_pop_valid  = !o_empty;
    assign o_pop_data   = r_mem[r_rd_ptr];
    assign w_push       = i_push_valid && o_push_ready;
    assign w_pop        = o_pop_valid && i_pop_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vx_csr_access.sv
// CSR access front-end: drives CSR read/write ports, computes the RMW value,
// stalls FP-CSR accesses behind pending FPU ops, queues responses to commit.
module vx_csr_access
    import vx_csr_access_pkg::*;
#(
    parameter int CORE_ID    = 0,
    parameter int QUEUE_SIZE = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [UUID_BITS-1:0]     i_req_uuid,
    input  logic [NW_BITS-1:0]       i_req_wid,
    input  logic [NUM_THREADS-1:0]   i_req_tmask,
    input  logic [31:0]              i_req_PC,
    input  logic [NR_BITS-1:0]       i_req_rd,
    input  logic                     i_req_wb,
    input  logic [1:0]               i_req_op,
    input  logic [CSR_ADDR_BITS-1:0] i_req_addr,
    input  logic [31:0]              i_req_src,
    input  logic                     i_req_src_zero,
    input  logic [NUM_WARPS-1:0]     i_fpu_pending,
    output logic                     o_read_enable,
    output logic [UUID_BITS-1:0]     o_read_uuid,
    output logic [CSR_ADDR_BITS-1:0] o_read_addr,
    output logic [NW_BITS-1:0]       o_read_wid,
    input  logic [31:0]              i_read_data,
    output logic                     o_write_enable,
    output logic [UUID_BITS-1:0]     o_write_uuid,
    output logic [CSR_ADDR_BITS-1:0] o_write_addr,
    output logic [NW_BITS-1:0]       o_write_wid,
    output logic [31:0]              o_write_data,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [UUID_BITS-1:0]     o_rsp_uuid,
    output logic [NW_BITS-1:0]       o_rsp_wid,
    output logic [NUM_THREADS-1:0]   o_rsp_tmask,
    output logic [31:0]              o_rsp_PC,
    output logic [NR_BITS-1:0]       o_rsp_rd,
    output logic                     o_rsp_wb,
    output logic [31:0]              o_rsp_data,
    output logic                     o_busy,
    output logic [PERF_CTR_BITS-1:0] o_perf_stalls
);

    csr_op_t                  w_op;
    logic                     w_illegal;
    logic                     w_hazard;
    logic                     w_fire;
    logic                     w_q_push_ready;
    logic                     w_q_full;
    logic                     w_q_empty;
    logic [31:0]              w_wdata;
    logic [31:0]              w_rsp_data;
    csr_rsp_t                 w_push_data;
    csr_rsp_t                 w_head;
    logic [PERF_CTR_BITS-1:0] r_perf_stalls;

    assign w_op      = csr_op_t'(i_req_op);
    assign w_illegal = (i_req_op == 2'd3);
    assign w_hazard  = is_fp_csr(i_req_addr) && i_fpu_pending[i_req_wid];

    assign o_req_ready = !w_hazard && w_q_push_ready;
    assign w_fire      = i_req_valid && o_req_ready;

    // An illegal op behaves as RW for the read side but never writes.
    assign o_read_enable  = w_fire
                         && ((w_op != CSR_RW && !w_illegal) || i_req_wb);
    assign o_write_enable = w_fire && !w_illegal
                         && (w_op == CSR_RW || !i_req_src_zero);

    always_comb begin
        w_wdata = i_req_src;
        unique case (w_op)
            CSR_RS:  w_wdata = i_read_data | i_req_src;
            CSR_RC:  w_wdata = i_read_data & ~i_req_src;
            default: w_wdata = i_req_src;
        endcase
    end

    assign o_read_uuid  = i_req_uuid;
    assign o_read_addr  = i_req_addr;
    assign o_read_wid   = i_req_wid;
    assign o_write_uuid = i_req_uuid;
    assign o_write_addr = i_req_addr;
    assign o_write_wid  = i_req_wid;
    assign o_write_data = w_wdata;

    assign w_rsp_data  = o_read_enable ? i_read_data : 32'h0;
    assign w_push_data = '{uuid:  i_req_uuid,
                           wid:   i_req_wid,
                           tmask: i_req_tmask,
                           pc:    i_req_PC,
                           rd:    i_req_rd,
                           wb:    i_req_wb,
                           data:  w_rsp_data};

    vx_csr_access_rsp_queue #(
        .DEPTH (QUEUE_SIZE)
    ) u_rsp_queue (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push_valid (w_fire),
        .o_push_ready (w_q_push_ready),
        .i_push_data  (w_push_data),
        .o_pop_valid  (o_rsp_valid),
        .i_pop_ready  (i_rsp_ready),
        .o_pop_data   (w_head),
        .o_full       (w_q_full),
        .o_empty      (w_q_empty)
    );

    assign o_rsp_uuid  = w_head.uuid;
    assign o_rsp_wid   = w_head.wid;
    assign o_rsp_tmask = w_head.tmask;
    assign o_rsp_PC    = w_head.pc;
    assign o_rsp_rd    = w_head.rd;
    assign o_rsp_wb    = w_head.wb;
    assign o_rsp_data  = w_head.data;

    assign o_busy        = i_req_valid || !w_q_empty;
    assign o_perf_stalls = r_perf_stalls;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perf_stalls <= '0;
        end else if (i_req_valid && !o_req_ready) begin
            r_perf_stalls <= r_perf_stalls + PERF_CTR_BITS'(1);
        end
    end

    a_legal_op: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_req_valid && w_illegal))
        else $error("core %0d: illegal CSR op", CORE_ID);

    a_no_push_full: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_fire && w_q_full));

endmodule

// File: tb/tb_vx_csr_access.sv
// Self-checking bench for vx_csr_access: directed table, hazard, backpressure,
// async reset sequences and a randomized run against a behavioural model.
module tb_vx_csr_access;
    import vx_csr_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_uuid;
    logic [1:0]  req_wid;
    logic [3:0]  req_tmask;
    logic [31:0] req_pc;
    logic [4:0]  req_rd;
    logic        req_wb;
    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_src;
    logic        req_sz;
    logic [3:0]  fpu_pending;
    logic        rd_en;
    logic [7:0]  rd_uuid;
    logic [11:0] rd_addr;
    logic [1:0]  rd_wid;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [7:0]  wr_uuid;
    logic [11:0] wr_addr;
    logic [1:0]  wr_wid;
    logic [31:0] wr_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_uuid;
    logic [1:0]  rsp_wid;
    logic [3:0]  rsp_tmask;
    logic [31:0] rsp_pc;
    logic [4:0]  rsp_rd;
    logic        rsp_wb;
    logic [31:0] rsp_data;
    logic        busy;
    logic [15:0] perf;

    vx_csr_access #(.CORE_ID(0), .QUEUE_SIZE(2)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_uuid(req_uuid), .i_req_wid(req_wid),
        .i_req_tmask(req_tmask), .i_req_PC(req_pc),
        .i_req_rd(req_rd), .i_req_wb(req_wb), .i_req_op(req_op),
        .i_req_addr(req_addr), .i_req_src(req_src),
        .i_req_src_zero(req_sz), .i_fpu_pending(fpu_pending),
        .o_read_enable(rd_en), .o_read_uuid(rd_uuid),
        .o_read_addr(rd_addr), .o_read_wid(rd_wid),
        .i_read_data(rd_data),
        .o_write_enable(wr_en), .o_write_uuid(wr_uuid),
        .o_write_addr(wr_addr), .o_write_wid(wr_wid),
        .o_write_data(wr_data),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_uuid(rsp_uuid), .o_rsp_wid(rsp_wid),
        .o_rsp_tmask(rsp_tmask), .o_rsp_PC(rsp_pc),
        .o_rsp_rd(rsp_rd), .o_rsp_wb(rsp_wb), .o_rsp_data(rsp_data),
        .o_busy(busy), .o_perf_stalls(perf)
    );

    always #5 clk = ~clk;

    // Bench-side CSR data block: combinational read, write commits at the edge.
    logic [31:0] mem [4096];
    logic        poke_en;
    logic [11:0] poke_addr;
    logic [31:0] poke_data;

    always_comb rd_data = mem[rd_addr];

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (wr_en) mem[wr_addr] <= wr_data;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        step();
        poke_en = 1'b0;
    endtask

    task automatic set_req(input logic [1:0] op, input logic [11:0] a,
                           input logic [31:0] s, input logic sz,
                           input logic wb, input logic [7:0] u,
                           input logic [1:0] w);
        req_valid = 1'b1; req_op = op; req_addr = a; req_src = s;
        req_sz = sz; req_wb = wb; req_uuid = u; req_wid = w;
        req_tmask = 4'hf; req_pc = 32'h1000 + 32'(u) * 4;
        req_rd = 5'(u);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] src;
        logic        sz;
        logic        wb;
        logic        re;
        logic        we;
        logic [31:0] wd;
        logic [31:0] rdat;
    } vec_t;

    typedef struct {
        logic [7:0]  uuid;
        logic [1:0]  wid;
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wb;
        logic [31:0] data;
    } exp_t;

    localparam logic [11:0] MSTATUS  = 12'h300;
    localparam logic [11:0] MTVEC    = 12'h305;
    localparam logic [11:0] MSCRATCH = 12'h340;

    vec_t        vecs [8];
    logic [31:0] ref_csr [4096];
    exp_t        mq [$];
    logic [11:0] addrs [6];
    logic [15:0] p0;

    initial begin
        vecs[0] = '{2'd1, MTVEC,    32'h3,        0, 1, 1, 1, 32'h103,      32'h100};
        vecs[1] = '{2'd2, MTVEC,    32'h1,        0, 1, 1, 1, 32'h102,      32'h103};
        vecs[2] = '{2'd1, MSTATUS,  32'h0,        1, 1, 1, 0, 32'h0,        32'h1800};
        vecs[3] = '{2'd0, MSCRATCH, 32'hdeadbeef, 0, 0, 0, 1, 32'hdeadbeef, 32'h0};
        vecs[4] = '{2'd0, MSCRATCH, 32'h12345678, 0, 1, 1, 1, 32'h12345678, 32'hdeadbeef};
        vecs[5] = '{2'd2, MSCRATCH, 32'hffff0000, 0, 1, 1, 1, 32'h00005678, 32'h12345678};
        vecs[6] = '{2'd1, MSCRATCH, 32'h0,        1, 0, 1, 0, 32'h0,        32'h5678};
        vecs[7] = '{2'd0, MSCRATCH, 32'h0,        1, 1, 1, 1, 32'h0,        32'h5678};
        addrs = '{CSR_FFLAGS, CSR_FRM, CSR_FCSR, MSTATUS, MTVEC, MSCRATCH};

        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; fpu_pending = '0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        set_req(2'd0, 12'h0, 32'h0, 0, 0, 8'h0, 2'd0);
        req_valid = 1'b0;
        #1;
        poke(MTVEC, 32'h100);
        poke(MSTATUS, 32'h1800);
        poke(MSCRATCH, 32'h0);

        // Reset state.
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_perf", perf, 0);
        chk("reset_rsp_uuid", rsp_uuid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_wr_en", wr_en, 0);
        rst = 1'b0;
        step();

        // Directed table with rsp_ready high: one response per cycle.
        for (int i = 0; i < 8; i++) begin
            set_req(vecs[i].op, vecs[i].addr, vecs[i].src, vecs[i].sz,
                    vecs[i].wb, 8'(i + 1), 2'd0);
            #1;
            chk($sformatf("tbl%0d_ready", i), req_ready, 1);
            chk($sformatf("tbl%0d_rd_en", i), rd_en, vecs[i].re);
            chk($sformatf("tbl%0d_wr_en", i), wr_en, vecs[i].we);
            if (vecs[i].we)
                chk($sformatf("tbl%0d_wdata", i), wr_data, vecs[i].wd);
            if (i > 0) begin
                chk($sformatf("tbl%0d_rsp_valid", i), rsp_valid, 1);
                chk($sformatf("tbl%0d_rsp_uuid", i), rsp_uuid, i);
                chk($sformatf("tbl%0d_rsp_data", i), rsp_data, vecs[i-1].rdat);
            end
            step();
        end
        req_valid = 1'b0;
        #1;
        chk("tbl_last_uuid", rsp_uuid, 8);
        chk("tbl_last_data", rsp_data, vecs[7].rdat);
        step();
        chk("tbl_drained", rsp_valid, 0);

        // FP-CSR hazard on warp 2.
        fpu_pending = 4'b0100;
        set_req(2'd1, CSR_FFLAGS, 32'h0, 1, 1, 8'h30, 2'd2);
        #1;
        p0 = perf;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("haz_ready%0d", i), req_ready, 0);
            step();
        end
        chk("haz_perf5", perf, p0 + 16'd5);
        set_req(2'd1, CSR_FFLAGS, 32'h0, 1, 1, 8'h31, 2'd1);
        #1;
        chk("haz_w1_ready", req_ready, 1);
        step();
        set_req(2'd1, CSR_FFLAGS, 32'h0, 1, 1, 8'h32, 2'd2);
        #1;
        chk("haz_w2_again", req_ready, 0);
        fpu_pending = 4'b0000;
        #1;
        chk("haz_clear_same_cycle", req_ready, 1);
        chk("haz_clear_rd_en", rd_en, 1);
        step();
        req_valid = 1'b0;
        chk("haz_no_extra_stall", perf, p0 + 16'd5);
        step(); step();

        // Backpressure: queue of 2 fills, third waits.
        rsp_ready = 1'b0;
        set_req(2'd0, MSCRATCH, 32'h10, 0, 1, 8'd10, 2'd0);
        #1; chk("bp_acc10", req_ready, 1); step();
        set_req(2'd0, MSCRATCH, 32'h11, 0, 1, 8'd11, 2'd0);
        #1; chk("bp_acc11", req_ready, 1); step();
        set_req(2'd0, MSCRATCH, 32'h12, 0, 1, 8'd12, 2'd0);
        #1; chk("bp_full_stall", req_ready, 0); step();
        chk("bp_hold_uuid", rsp_uuid, 10);
        rsp_ready = 1'b1;
        #1;
        chk("bp_full_pop_ready", req_ready, 0);
        chk("bp_head10", rsp_uuid, 10);
        step();
        chk("bp_resume", req_ready, 1);
        chk("bp_head11", rsp_uuid, 11);
        chk("bp_head11_data", rsp_data, 32'h10);
        step();
        req_valid = 1'b0;
        #1;
        chk("bp_head12", rsp_uuid, 12);
        chk("bp_head12_valid", rsp_valid, 1);
        step();
        chk("bp_empty", rsp_valid, 0);

        // Async reset with two entries queued.
        rsp_ready = 1'b0;
        set_req(2'd0, MSCRATCH, 32'h20, 0, 1, 8'd20, 2'd0); step();
        set_req(2'd0, MSCRATCH, 32'h21, 0, 1, 8'd21, 2'd0); step();
        set_req(2'd0, MSCRATCH, 32'h22, 0, 1, 8'd22, 2'd0); step();
        chk("ar_pre_valid", rsp_valid, 1);
        chk("ar_pre_perf_nz", perf != 16'd0, 1);
        #2;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("ar_rsp_valid", rsp_valid, 0);
        chk("ar_perf", perf, 0);
        chk("ar_busy", busy, 0);
        chk("ar_rsp_uuid", rsp_uuid, 0);
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        step();

        // Randomized run against a behavioural model.
        for (int i = 0; i < 6; i++) begin
            logic [31:0] v;
            v = $urandom;
            poke(addrs[i], v);
            ref_csr[addrs[i]] = v;
        end
        for (int c = 0; c < 600; c++) begin
            logic        fire, haz, do_rd, do_wr;
            logic [31:0] old, nv;
            exp_t        e;
            req_valid   = ($urandom_range(0, 9) < 7);
            req_op      = 2'($urandom_range(0, 2));
            req_addr    = addrs[$urandom_range(0, 5)];
            req_wid     = 2'($urandom);
            req_src     = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            req_sz      = 1'($urandom);
            req_wb      = 1'($urandom);
            req_uuid    = 8'($urandom);
            req_tmask   = 4'($urandom);
            req_pc      = $urandom;
            req_rd      = 5'($urandom);
            fpu_pending = 4'($urandom);
            rsp_ready   = 1'($urandom);
            #1;
            haz  = (req_addr inside {CSR_FFLAGS, CSR_FRM, CSR_FCSR})
                && fpu_pending[req_wid];
            fire = req_valid && !haz && (mq.size() < 2);
            chk("rnd_ready", req_ready, !haz && (mq.size() < 2));
            chk("rnd_busy", busy, req_valid || (mq.size() != 0));
            chk("rnd_rsp_valid", rsp_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("rnd_rsp", {rsp_uuid, rsp_wid, rsp_tmask, rsp_pc,
                                rsp_rd, rsp_wb, rsp_data},
                    {mq[0].uuid, mq[0].wid, mq[0].tmask, mq[0].pc,
                     mq[0].rd, mq[0].wb, mq[0].data});
            end
            old   = ref_csr[req_addr];
            do_rd = fire && (req_op != 2'd0 || req_wb);
            do_wr = fire && (req_op == 2'd0 || !req_sz);
            case (req_op)
                2'd1:    nv = old | req_src;
                2'd2:    nv = old & ~req_src;
                default: nv = req_src;
            endcase
            chk("rnd_rd_en", rd_en, do_rd);
            chk("rnd_wr_en", wr_en, do_wr);
            if (do_wr) chk("rnd_wdata", wr_data, nv);
            if (rsp_ready && mq.size() != 0) void'(mq.pop_front());
            if (fire) begin
                e = '{req_uuid, req_wid, req_tmask, req_pc, req_rd, req_wb,
                      do_rd ? old : 32'h0};
                mq.push_back(e);
            end
            if (do_wr) ref_csr[req_addr] = nv;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vx_csr_access.md
# VX_csr_access

Front-end stage of the CSR path: accepts decoded CSR instructions (CSRRW/CSRRS/CSRRC, register or immediate source) from the issue stage and drives the read and write ports of the per-core CSR data block. It computes the read-modify-write value and holds back FP-CSR accesses while that warp has FPU operations in flight. Results are buffered in a 2-entry queue toward writeback/commit.

## Interface
- CORE_ID, 0, core index, carried for debug prints only
- QUEUE_SIZE, 2, result queue depth (power of 2, ≥2)
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid / req_ready  in / out  1 / 1  request handshake
- req_uuid  in  `UUID_BITS  instruction tag
- req_wid  in  `NW_BITS  warp id
- req_tmask  in  `NUM_THREADS  thread mask
- req_PC  in  32  instruction PC
- req_rd  in  `NR_BITS  destination register
- req_wb  in  1  destination is not x0
- req_op  in  2  csr_op_t: RW=0, RS=1, RC=2 (3 illegal)
- req_addr  in  `CSR_ADDR_BITS  CSR address
- req_src  in  32  rs1 value of first active thread, or zero-extended uimm
- req_src_zero  in  1  rs1 field is x0 / uimm field is 0
- fpu_pending  in  `NUM_WARPS  per-warp FPU ops outstanding
- read_enable, read_uuid, read_addr, read_wid  out  1, `UUID_BITS, `CSR_ADDR_BITS, `NW_BITS  CSR read port
- read_data  in  32  combinational read result
- write_enable, write_uuid, write_addr, write_wid, write_data  out  1, `UUID_BITS, `CSR_ADDR_BITS, `NW_BITS, 32  CSR write port
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake
- rsp_uuid, rsp_wid, rsp_tmask, rsp_PC, rsp_rd, rsp_wb  out  as request fields  passed through
- rsp_data  out  32  old CSR value; downstream replicates it across threads
- busy  out  1  req_valid or queue non-empty
- perf_stalls  out  `PERF_CTR_BITS  cycles with req_valid && !req_ready

## Operation
- fire = req_valid && req_ready.
- fp_csr = req_addr ∈ {CSR_FFLAGS, CSR_FRM, CSR_FCSR}.
- hazard = fp_csr && fpu_pending[req_wid].
- req_ready = !hazard && (count < QUEUE_SIZE). It does not depend on rsp_ready.
- Read port: read_enable = fire && (req_op != RW || req_wb). read_addr, read_wid and read_uuid always follow the req_* fields.
- Write value:
  - RW: req_src
  - RS: read_data | req_src
  - RC: read_data & ~req_src
- Write port: write_enable = fire && (req_op == RW || !req_src_zero). The write is issued in the same cycle as the read; the CSR block commits it at the next edge.
- rsp_data = read_data when a read occurs, else 0.
- On fire, {passthrough fields, rsp_data} is pushed into the queue. The head is presented on rsp_*, and rsp_valid = count != 0.
- req_op == 3 with req_valid: simulation assertion. The request is still accepted and treated as RW with write_enable forced to 0.
- perf_stalls increments by 1 per stall cycle and wraps at 2^`PERF_CTR_BITS.

## Timing
- Reset (async assert, sync deassert assumed upstream):
  - queue empty, rsp_valid=0, busy=0 unless req_valid, perf_stalls=0
  - all rsp_* data fields = 0; read/write enables depend only on fire
- Latency: fire in cycle N → rsp_valid in cycle N+1 (registered queue). Throughput is 1 per cycle while rsp_ready stays high.
- Back-to-back requests to the same CSR: the second read in cycle N+1 sees the write from cycle N.
- Queue full (count == QUEUE_SIZE): req_ready=0 even if rsp_ready=1 in the same cycle. Acceptance resumes the next cycle.
- Simultaneous push and pop: count unchanged, order preserved.
- rsp_* must hold stable while rsp_valid && !rsp_ready.
- Hazard clears (fpu_pending drops) in cycle N → req_ready may rise in cycle N (combinational).
- Reset mid-operation: queued responses are discarded. Writes already issued are not undone.

## Structure
- Package VX_csr_pkg holds:
  - csr_op_t enum
  - csr_rsp_t packed struct (uuid, wid, tmask, PC, rd, wb, data)
  - the FP-CSR address list as localparams
- One sub-module, VX_csr_rsp_queue: parameterised-depth FIFO of csr_rsp_t with valid/ready on both sides, full/empty flags, and the same clk/reset.
- Read/write logic and the hazard check stay in the top module.

## Test plan
- Register the test CSR_MSCRATCH-equivalent, then CSRRS:
  - initial CSR_MTVEC=0x0000_0100
  - CSRRS src=0x0000_0003 → rsp_data=0x100, write_data=0x103
  - following CSRRC src=0x1 → rsp_data=0x103, write_data=0x102
- CSRRS with req_src_zero=1 on CSR_MSTATUS → write_enable stays 0 and rsp_data returns the current value.
- CSRRW with req_wb=0 → read_enable=0, rsp_data=0, write issued.
- FP-CSR hazard:
  - fpu_pending[2]=1, CSR_FFLAGS read for warp 2 → req_ready=0; perf_stalls counts 5 over 5 cycles
  - fpu_pending drops → accepted the same cycle
  - a warp-1 request during the stall proceeds
- Backpressure:
  - rsp_ready=0, send 3 requests → first 2 accepted, third stalls
  - raise rsp_ready → responses drain in order, uuids 10, 11, 12
- Async reset asserted mid-stream with 2 entries queued → rsp_valid=0 immediately (before the next edge) and perf_stalls=0.
